// File: rtl/vrf_wb_arbiter.sv
// Per-lane VRF write-back arbiter: round-robin over result requesters into a one-entry output slot.
// Optional macro WB_ZERO_STRB_DROP_EN: zero-strobe beats are consumed and retired without a VRF write.
module vrf_wb_arbiter #(
    parameter int NrReq  = 3,
    parameter int LaneId = 0,
    parameter int DataW  = 64,
    parameter int StrbW  = DataW / 8,
    parameter int AddrW  = 8,
    parameter int IdW    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NrReq-1:0]       req_valid_i,
    output logic [NrReq-1:0]       req_gnt_o,
    input  logic [NrReq*DataW-1:0] req_wdata_i,
    input  logic [NrReq*StrbW-1:0] req_wstrb_i,
    input  logic [NrReq*AddrW-1:0] req_addr_i,
    input  logic [NrReq*IdW-1:0]   req_id_i,
    output logic                   vrf_wr_valid_o,
    input  logic                   vrf_wr_ready_i,
    output logic [DataW-1:0]       vrf_wdata_o,
    output logic [StrbW-1:0]       vrf_wstrb_o,
    output logic [AddrW-1:0]       vrf_waddr_o,
    output logic                   wb_valid_o,
    output logic [IdW-1:0]         wb_id_o
);

    localparam int PtrW = (NrReq > 1) ? $clog2(NrReq) : 1;

    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [DataW-1:0] data_q, data_d;
    logic [StrbW-1:0] strb_q, strb_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [IdW-1:0]   id_q, id_d;

    logic [PtrW-1:0]  win;
    logic [PtrW-1:0]  idx_w;
    logic             found;
    int               idx;
    logic             accept, gnt_any, drain, drop;
    logic [DataW-1:0] win_data;
    logic [StrbW-1:0] win_strb;
    logic [AddrW-1:0] win_addr;
    logic [IdW-1:0]   win_id;

    // Scan starts at rr_ptr_q and wraps, so the last winner has lowest priority next time.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int i = 0; i < NrReq; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NrReq) idx = idx - NrReq;
            idx_w = idx[PtrW-1:0];
            if (!found && req_valid_i[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    assign win_data = req_wdata_i[int'(win)*DataW +: DataW];
    assign win_strb = req_wstrb_i[int'(win)*StrbW +: StrbW];
    assign win_addr = req_addr_i[int'(win)*AddrW +: AddrW];
    assign win_id   = req_id_i[int'(win)*IdW +: IdW];

    assign accept  = !out_valid_q || vrf_wr_ready_i;
    assign gnt_any = accept && found;
    assign drain   = out_valid_q && vrf_wr_ready_i;

`ifdef WB_ZERO_STRB_DROP_EN
    assign drop = gnt_any && (win_strb == '0);
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        req_gnt_o = '0;
        if (gnt_any) req_gnt_o[win] = 1'b1;
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        strb_d      = strb_q;
        addr_d      = addr_q;
        id_d        = id_q;
        if (gnt_any) rr_ptr_d = (win == PtrW'(NrReq - 1)) ? '0 : win + 1'b1;
        if (gnt_any && !drop) begin
            out_valid_d = 1'b1;
            data_d      = win_data;
            strb_d      = win_strb;
            addr_d      = win_addr;
            id_d        = win_id;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            strb_q      <= '0;
            addr_q      <= '0;
            id_q        <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
        end
    end

    assign vrf_wr_valid_o = out_valid_q;
    assign vrf_wdata_o    = data_q;
    assign vrf_wstrb_o    = strb_q;
    assign vrf_waddr_o    = addr_q;

`ifdef WB_ZERO_STRB_DROP_EN
    logic           pend_valid_q, pend_valid_d;
    logic [IdW-1:0] pend_id_q, pend_id_d;

    // A pending drop always leaves the slot empty, so it never collides with a drain next cycle.
    always_comb begin
        pend_valid_d = drop && (drain || pend_valid_q);
        pend_id_d    = drop ? win_id : pend_id_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
        end
    end

    assign wb_valid_o = drain || pend_valid_q || drop;
    assign wb_id_o    = drain        ? id_q      :
                        pend_valid_q ? pend_id_q :
                        drop         ? win_id    : id_q;

`ifndef SYNTHESIS
    a_pend_slot_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pend_valid_q |-> !out_valid_q)
        else $error("lane %0d: pending drop overlaps a held beat", LaneId);
`endif
`else
    assign wb_valid_o = drain;
    assign wb_id_o    = id_q;
`endif

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_gnt_o))
        else $error("lane %0d: more than one grant", LaneId);
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (vrf_wr_valid_o && !vrf_wr_ready_i) |=> (vrf_wr_valid_o && $stable(vrf_wdata_o) &&
        $stable(vrf_wstrb_o) && $stable(vrf_waddr_o)))
        else $error("lane %0d: write beat changed while stalled", LaneId);
`endif

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Scoreboard bench for vrf_wb_arbiter (NrReq=3): directed beats, queued expectations, negedge monitor.
module tb_vrf_wb_arbiter;

    localparam int NR = 3;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int AW = 8;
    localparam int IW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [IW-1:0] id;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_gnt;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SW-1:0] req_wstrb;
    logic [NR*AW-1:0] req_addr;
    logic [NR*IW-1:0] req_id;
    logic             wr_valid;
    logic             wr_ready;
    logic [DW-1:0]    wdata;
    logic [SW-1:0]    wstrb;
    logic [AW-1:0]    waddr;
    logic             wb_valid;
    logic [IW-1:0]    wb_id;

    vrf_wb_arbiter #(.NrReq(NR), .LaneId(0), .DataW(DW), .StrbW(SW), .AddrW(AW), .IdW(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_gnt_o(req_gnt),
        .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb), .req_addr_i(req_addr), .req_id_i(req_id),
        .vrf_wr_valid_o(wr_valid), .vrf_wr_ready_i(wr_ready),
        .vrf_wdata_o(wdata), .vrf_wstrb_o(wstrb), .vrf_waddr_o(waddr),
        .wb_valid_o(wb_valid), .wb_id_o(wb_id)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    beat_t rq0[$], rq1[$], rq2[$];
    int    exp_gnt[$];
    beat_t exp_wr[$];
    int    exp_wb[$];

    task automatic cmp(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [IW-1:0] i);
        beat_t b;
        b.addr = a;
        b.data = {8{a}} ^ 64'h0123_4567_89AB_CDEF;
        b.strb = s;
        b.id   = i;
        return b;
    endfunction

    task automatic put(input int r, input beat_t b);
        case (r)
            0: rq0.push_back(b);
            1: rq1.push_back(b);
            default: rq2.push_back(b);
        endcase
    endtask

    task automatic expect_write(input beat_t b);
        exp_wr.push_back(b);
        exp_wb.push_back(int'(b.id));
    endtask

    task automatic drive();
        beat_t f;
        req_valid = {rq2.size() > 0, rq1.size() > 0, rq0.size() > 0};
        for (int r = 0; r < NR; r++) begin
            f = '0;
            if (r == 0 && rq0.size() > 0) f = rq0[0];
            if (r == 1 && rq1.size() > 0) f = rq1[0];
            if (r == 2 && rq2.size() > 0) f = rq2[0];
            req_wdata[r*DW +: DW] = f.data;
            req_wstrb[r*SW +: SW] = f.strb;
            req_addr[r*AW +: AW]  = f.addr;
            req_id[r*IW +: IW]    = f.id;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Requester model: pops its FIFO head when granted, holds it otherwise.
    initial begin
        logic [NR-1:0] gs;
        forever begin
            @(negedge clk);
            gs = req_gnt;
            @(posedge clk);
            #1;
            if (gs[0] && rq0.size() > 0) void'(rq0.pop_front());
            if (gs[1] && rq1.size() > 0) void'(rq1.pop_front());
            if (gs[2] && rq2.size() > 0) void'(rq2.pop_front());
            drive();
        end
    end

    // Monitor: every grant, VRF write and completion pulse is popped against its queue.
    initial begin
        int    gi;
        int    e;
        beat_t eb;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_gnt != '0) begin
                    gi = 0;
                    for (int r = 0; r < NR; r++) if (req_gnt[r]) gi = r;
                    cmp("gnt_onehot", 96'($countones(req_gnt)), 96'(1));
                    if (exp_gnt.size() == 0) cmp("unexpected_gnt", 96'(req_gnt), 96'(0));
                    else begin
                        e = exp_gnt.pop_front();
                        cmp("gnt_idx", 96'(gi), 96'(e));
                    end
                end
                if (wr_valid && wr_ready) begin
                    if (exp_wr.size() == 0) cmp("unexpected_write", 96'(waddr), 96'(0));
                    else begin
                        eb = exp_wr.pop_front();
                        cmp("wr_addr", 96'(waddr), 96'(eb.addr));
                        cmp("wr_data", 96'(wdata), 96'(eb.data));
                        cmp("wr_strb", 96'(wstrb), 96'(eb.strb));
                    end
                end
                if (wb_valid) begin
                    if (exp_wb.size() == 0) cmp("unexpected_wb", 96'(wb_id), 96'(0));
                    else begin
                        e = exp_wb.pop_front();
                        cmp("wb_id", 96'(wb_id), 96'(e));
                    end
                end
            end
        end
    end

    task automatic wait_drain(input string tag);
        int left;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            left = exp_gnt.size() + exp_wr.size() + exp_wb.size() + rq0.size() + rq1.size() + rq2.size();
            if (left == 0) break;
        end
        left = exp_gnt.size() + exp_wr.size() + exp_wb.size() + rq0.size() + rq1.size() + rq2.size();
        cmp({"drain_", tag}, 96'(left), 96'(0));
    endtask

    initial begin
        beat_t b;
        rst_n     = 1'b0;
        wr_ready  = 1'b1;
        req_valid = '0;
        req_wdata = '0;
        req_wstrb = '0;
        req_addr  = '0;
        req_id    = '0;
        repeat (3) @(negedge clk);
        cmp("rst_gnt",   96'(req_gnt),  96'(0));
        cmp("rst_valid", 96'(wr_valid), 96'(0));
        cmp("rst_data",  96'(wdata),    96'(0));
        cmp("rst_strb",  96'(wstrb),    96'(0));
        cmp("rst_addr",  96'(waddr),    96'(0));
        cmp("rst_wb",    96'({wb_valid, wb_id}), 96'(0));
        #3 rst_n = 1'b1;
        step();

        // r0 alone, 4 beats back to back
        for (int i = 0; i < 4; i++) begin
            b = mk(8'h10 + 8'(i), 8'hFF, 4'(1 + i));
            put(0, b);
            exp_gnt.push_back(0);
            expect_write(b);
        end
        step();
        @(negedge clk);
        cmp("lat_gnt_c0",   96'(req_gnt),  96'(3'b001));
        cmp("lat_valid_c0", 96'(wr_valid), 96'(0));
        step();
        @(negedge clk);
        cmp("lat_valid_c1", 96'(wr_valid), 96'(1));
        cmp("lat_addr_c1",  96'(waddr),    96'(8'h10));
        wait_drain("r0_stream");

        // r1 with VRF back-pressure
        step();
        wr_ready = 1'b0;
        put(1, mk(8'h30, 8'hF0, 4'd5));
        put(1, mk(8'h31, 8'h0F, 4'd6));
        exp_gnt.push_back(1);
        exp_gnt.push_back(1);
        expect_write(mk(8'h30, 8'hF0, 4'd5));
        expect_write(mk(8'h31, 8'h0F, 4'd6));
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            cmp("stall_gnt",   96'(req_gnt),  96'(0));
            cmp("stall_valid", 96'(wr_valid), 96'(1));
            cmp("stall_addr",  96'(waddr),    96'(8'h30));
            cmp("stall_wb",    96'(wb_valid), 96'(0));
        end
        step();
        wr_ready = 1'b1;
        wait_drain("stall");

        // zero-strobe beat on r2
        step();
        b = mk(8'h20, 8'h00, 4'd7);
        put(2, b);
        exp_gnt.push_back(2);
`ifdef WB_ZERO_STRB_DROP_EN
        exp_wb.push_back(7);
        step();
        @(negedge clk);
        cmp("drop_wb_valid", 96'(wb_valid), 96'(1));
        cmp("drop_wb_id",    96'(wb_id),    96'(7));
        step();
        @(negedge clk);
        cmp("drop_no_write", 96'(wr_valid), 96'(0));
`else
        expect_write(b);
        step();
        step();
        @(negedge clk);
        cmp("zs_valid", 96'(wr_valid), 96'(1));
        cmp("zs_addr",  96'(waddr),    96'(8'h20));
        cmp("zs_strb",  96'(wstrb),    96'(0));
`endif
        wait_drain("zero_strb");

        // all three continuously valid: order 0,1,2,0,1,2
        step();
        for (int j = 0; j < 2; j++)
            for (int r = 0; r < NR; r++) begin
                b = mk(8'h40 + 8'(3 * j + r), 8'hFF, 4'(8 + 3 * j + r));
                put(r, b);
            end
        for (int j = 0; j < 2; j++)
            for (int r = 0; r < NR; r++) begin
                exp_gnt.push_back(r);
                expect_write(mk(8'h40 + 8'(3 * j + r), 8'hFF, 4'(8 + 3 * j + r)));
            end
        wait_drain("round_robin");

        // reset while a beat is held
        step();
        wr_ready = 1'b0;
        put(0, mk(8'h50, 8'hFF, 4'd14));
        put(1, mk(8'h51, 8'hFF, 4'd15));
        exp_gnt.push_back(0);
        step();
        step();
        @(negedge clk);
        cmp("pre_rst_valid", 96'(wr_valid), 96'(1));
        cmp("pre_rst_addr",  96'(waddr),    96'(8'h50));
        #3;
        rst_n = 1'b0;
        rq0.delete();
        rq1.delete();
        rq2.delete();
        drive();
        #1;
        cmp("mid_rst_valid", 96'(wr_valid), 96'(0));
        cmp("mid_rst_addr",  96'(waddr),    96'(0));
        cmp("mid_rst_data",  96'(wdata),    96'(0));
        cmp("mid_rst_wb",    96'(wb_valid), 96'(0));
        cmp("mid_rst_gnt",   96'(req_gnt),  96'(0));
        exp_gnt.delete();
        exp_wr.delete();
        exp_wb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        step();
        wr_ready = 1'b1;
        put(2, mk(8'h60, 8'hFF, 4'd1));
        put(0, mk(8'h61, 8'hFF, 4'd2));
        exp_gnt.push_back(0);
        exp_gnt.push_back(2);
        expect_write(mk(8'h61, 8'hFF, 4'd2));
        expect_write(mk(8'h60, 8'hFF, 4'd1));
        wait_drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
